piso_serializer: RTL

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock on `ser_out`. It is the transmit end of the serial link whose receive end is the right-shift receiver `shift_register_right` (serial in, parallel out). With `LSB_FIRST=1`, a receiver that shifts right on the same enables holds the original word on `q` after WIDTH shifts. Back-to-back loads produce a gapless bit stream.

---
 rtl/piso_pkg.sv | 8 +
 rtl/piso_bit_counter.sv | 38 +++
 rtl/piso_serializer.sv | 90 +++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one frame: clear wins over enable, last flags position WIDTH-1.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and gapless back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt;
  logic             cntLast, lastShift, accept, cntEn, cntClr;

  assign lastShift  = (state_q == SHIFT) && shift_en && cntLast;
  assign load_ready = rst_n && ((state_q == IDLE) || lastShift);
  assign accept     = load_valid && load_ready;
  assign shifted    = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
  assign cntEn      = (state_q == SHIFT) && shift_en;
  // Clearing on the final bit keeps the counter at 0 while idle.
  assign cntClr     = accept || lastShift;

  piso_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cntClr),
    .en_i   (cntEn),
    .cnt_o  (cnt),
    .last_o (cntLast)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shreg_d = shifted;
          if (cntLast) begin
            done_d = 1'b1;
            if (accept) begin
              shreg_d = load_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign ser_valid   = (state_q == SHIFT);
  assign ser_out     = ser_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign frame_start = ser_valid && (cnt == '0);
  assign done        = done_q;

endmodule
